// File: rtl/cnt_slice_pkg.sv
// Shared types and constants for the cascadable up/down counter slice.
// Optional saturate mode is selected by CNT_SLICE_SATURATE_EN.
package cnt_slice_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Largest value representable in `width` bits; default MAX_VAL.
  function automatic int unsigned default_max_val(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_CLR,
    SEL_LOAD,
    SEL_CNT,
    SEL_HOLD
  } sel_e;

endpackage

// File: rtl/cnt_term_detect.sv
// Terminal-value detector: at_term ignores en_t, tc is gated by en_t for cascading.
module cnt_term_detect
  import cnt_slice_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL = default_max_val(DEFAULT_WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic             en_t,
  output logic             at_term,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  assign at_term = (dir == DIR_UP) ? (q == MAX_Q) : (q == '0);
  assign tc      = en_t & at_term;

endmodule

// File: rtl/cnt_slice_ud.sv
// Cascadable synchronous up/down counter slice with clamped load, clear and terminal carry.
// Define CNT_SLICE_SATURATE_EN to hold at the terminal value instead of wrapping (adds sat).
module cnt_slice_ud
  import cnt_slice_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL = default_max_val(WIDTH),
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en_p,
  input  logic             en_t,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef CNT_SLICE_SATURATE_EN
  ,
  output logic             sat
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q      = WIDTH'(RST_VAL);
  localparam bit               FULL_RANGE = (MAX_VAL == default_max_val(WIDTH));

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_load_q;
  logic             w_at_term;
  logic             w_tc;
  sel_e             w_sel;

  cnt_term_detect #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL)
  ) u_term (
    .q      (r_q),
    .dir    (dir),
    .en_t   (en_t),
    .at_term(w_at_term),
    .tc     (w_tc)
  );

  // Clamp loads so q can never exceed MAX_VAL.
  if (FULL_RANGE) begin : g_load_full
    assign w_load_q = load_val;
  end else begin : g_load_clamp
    assign w_load_q = (load_val > MAX_Q) ? MAX_Q : load_val;
  end

  always_comb begin
    w_sel = SEL_HOLD;
    if (rst)              w_sel = SEL_RST;
    else if (clr)         w_sel = SEL_CLR;
    else if (load)        w_sel = SEL_LOAD;
    else if (en_p & en_t) w_sel = SEL_CNT;
  end

`ifdef CNT_SLICE_SATURATE_EN
  logic r_sat;
  logic w_sat_next;

  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    w_sat_next  = r_sat;
    unique case (w_sel)
      SEL_RST:  begin w_q_next = RST_Q;    w_sat_next = 1'b0; end
      SEL_CLR:  begin w_q_next = '0;       w_sat_next = 1'b0; end
      SEL_LOAD: begin w_q_next = w_load_q; w_sat_next = 1'b0; end
      SEL_CNT: begin
        if (w_at_term) begin
          w_sat_next = 1'b1;
        end else begin
          w_q_next   = (dir == DIR_UP) ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
          w_sat_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_sat <= 1'b0;
    else     r_sat <= w_sat_next;
  end

  assign sat = r_sat;
`else
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    unique case (w_sel)
      SEL_RST:  w_q_next = RST_Q;
      SEL_CLR:  w_q_next = '0;
      SEL_LOAD: w_q_next = w_load_q;
      SEL_CNT: begin
        if (w_at_term) begin
          w_q_next    = (dir == DIR_UP) ? '0 : MAX_Q;
          w_wrap_next = 1'b1;
        end else begin
          w_q_next = (dir == DIR_UP) ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RST_Q;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = w_tc;

endmodule
